// File: rtl/fetch_ctrl_pkg.sv
// Shared types and helpers for the fetch run controller.
package fetch_ctrl_pkg;

  localparam int unsigned PC_W_DEFAULT  = 7;
  localparam int unsigned CNT_W_DEFAULT = 16;

  typedef enum logic [1:0] {
    StIdle,
    StLaunch,
    StRun,
    StDone
  } fetch_ctrl_state_t;

  // Start address for a program index; indices past NUM_PROG are filtered by the caller.
  function automatic int unsigned prog_addr(input logic [1:0] idx,
                                            input int unsigned a0, input int unsigned a1,
                                            input int unsigned a2, input int unsigned a3);
    int unsigned addr;
    case (idx)
      2'd0:    addr = a0;
      2'd1:    addr = a1;
      2'd2:    addr = a2;
      default: addr = a3;
    endcase
    return addr;
  endfunction

endpackage

// File: rtl/fetch_run_controller.sv
// Launches one program run on the fetch unit, waits for core halt or watchdog,
// and reports completion with the run length.
module fetch_run_controller
  import fetch_ctrl_pkg::*;
#(
  parameter int unsigned PC_W       = PC_W_DEFAULT,
  parameter int unsigned NUM_PROG   = 3,
  parameter int unsigned PROG0_ADDR = 0,
  parameter int unsigned PROG1_ADDR = 40,
  parameter int unsigned PROG2_ADDR = 80,
  parameter int unsigned PROG3_ADDR = 120,
  parameter int unsigned CNT_W      = CNT_W_DEFAULT,
  parameter int unsigned TIMEOUT    = 1000
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             req_valid,
  input  logic [1:0]       req_prog,
  output logic             req_ready,
  input  logic             core_halt,
  output logic             fetch_start,
  output logic [PC_W-1:0]  fetch_start_address,
  output logic             fetch_halt,
  output logic             run_done,
  output logic             timed_out,
  output logic             req_error,
  output logic [CNT_W-1:0] cycle_count,
  output logic [1:0]       last_prog
);

  fetch_ctrl_state_t state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              timed_out_q, timed_out_d;
  logic [1:0]        last_prog_q, last_prog_d;
  logic              req_error_q, req_error_d;

  // One bit wider than the counter so the compare cannot wrap.
  logic [CNT_W:0] k_next;
  logic           at_timeout;
  logic           prog_ok;

  assign k_next     = {1'b0, cnt_q} + (CNT_W+1)'(1);
  assign at_timeout = (k_next == (CNT_W+1)'(TIMEOUT));
  assign prog_ok    = (32'(req_prog) < NUM_PROG);

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q     <= StIdle;
      cnt_q       <= '0;
      timed_out_q <= 1'b0;
      last_prog_q <= 2'd0;
      req_error_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      timed_out_q <= timed_out_d;
      last_prog_q <= last_prog_d;
      req_error_q <= req_error_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    timed_out_d = timed_out_q;
    last_prog_d = last_prog_q;
    req_error_d = 1'b0;
    case (state_q)
      StIdle: begin
        if (req_valid) begin
          if (prog_ok) begin
            last_prog_d = req_prog;
            cnt_d       = '0;
            timed_out_d = 1'b0;
            state_d     = StLaunch;
          end else begin
            req_error_d = 1'b1;
          end
        end
      end
      StLaunch: state_d = StRun;
      StRun: begin
        cnt_d = k_next[CNT_W-1:0];
        // Halt takes priority over the watchdog on the same cycle.
        if (core_halt) begin
          state_d = StDone;
        end else if (at_timeout) begin
          state_d     = StDone;
          timed_out_d = 1'b1;
        end
      end
      StDone:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  assign req_ready           = (state_q == StIdle);
  assign fetch_start         = (state_q == StLaunch);
  assign fetch_start_address = (state_q == StLaunch)
                               ? PC_W'(prog_addr(last_prog_q, PROG0_ADDR, PROG1_ADDR,
                                                 PROG2_ADDR, PROG3_ADDR))
                               : '0;
  assign fetch_halt          = (state_q == StIdle) || (state_q == StDone);
  assign run_done            = (state_q == StDone);
  assign timed_out           = timed_out_q;
  assign req_error           = req_error_q;
  assign cycle_count         = cnt_q;
  assign last_prog           = last_prog_q;

endmodule
